// File: rtl/scale_arb_mux.sv
// Chans-to-1 valid/ready multiplexer with a registered output stage, selecting by explicit sel or round-robin.
// Optional even-parity output out_par is enabled by defining SCALE_ARB_MUX_PARITY_EN.
module scale_arb_mux #(
    parameter int unsigned  Size  = 1,
    parameter int unsigned  Chans = 4,
    localparam int unsigned SelW  = $clog2(Chans)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [Chans*Size-1:0] in_data,
    input  logic [Chans-1:0]      in_valid,
    output logic [Chans-1:0]      in_ready,
    input  logic                  mode,
    input  logic [SelW-1:0]       sel,
    output logic [Size-1:0]       out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SelW-1:0]       out_chan
`ifdef SCALE_ARB_MUX_PARITY_EN
    ,
    output logic                  out_par
`endif
);

    logic              out_valid_q, out_valid_d;
    logic [Size-1:0]   out_data_q, out_data_d;
    logic [SelW-1:0]   out_chan_q, out_chan_d;
    logic [SelW-1:0]   rr_ptr_q, rr_ptr_d;

    logic              load_en_c;
    logic              grant_vld_c;
    logic [SelW-1:0]   grant_c;
    logic              xfer_c;
    logic [Size-1:0]   grant_data_c;
    int unsigned       dist_c;
    int unsigned       best_dist_c;

    assign load_en_c = !out_valid_q || out_ready;

    // Grant: explicit sel match, or the valid channel closest after rr_ptr in wrap order
    always_comb begin
        grant_vld_c = 1'b0;
        grant_c     = '0;
        dist_c      = 0;
        best_dist_c = Chans;
        for (int unsigned i = 0; i < Chans; i++) begin
            if (!mode) begin
                if (sel == SelW'(i) && in_valid[i]) begin
                    grant_vld_c = 1'b1;
                    grant_c     = SelW'(i);
                end
            end else begin
                dist_c = (i + Chans - 1 - 32'(rr_ptr_q)) % Chans;
                if (in_valid[i] && dist_c < best_dist_c) begin
                    best_dist_c = dist_c;
                    grant_vld_c = 1'b1;
                    grant_c     = SelW'(i);
                end
            end
        end
    end

    always_comb begin
        grant_data_c = '0;
        for (int unsigned i = 0; i < Chans; i++) begin
            if (grant_c == SelW'(i)) begin
                grant_data_c = in_data[i*Size +: Size];
            end
        end
    end

    assign xfer_c = grant_vld_c && load_en_c;

    // Ready is forced low while reset is asserted so no producer sees a handshake
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < Chans; i++) begin
            in_ready[i] = rst_n && xfer_c && (grant_c == SelW'(i));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer_c) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data_c;
            out_chan_d  = grant_c;
            if (mode) begin
                rr_ptr_d = grant_c;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= SelW'(Chans - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

`ifdef SCALE_ARB_MUX_PARITY_EN
    logic out_par_q, out_par_d;

    assign out_par_d = ^out_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par_q <= 1'b0;
        end else begin
            out_par_q <= out_par_d;
        end
    end

    assign out_par = out_par_q;
`endif

endmodule

// File: tb/tb_scale_arb_mux.sv
// Bench for scale_arb_mux (Size=8, Chans=4): vector table, hand-written corner sequences and
// randomized traffic against a behavioural model; parity checks when SCALE_ARB_MUX_PARITY_EN is defined.
module tb_scale_arb_mux;

    localparam int unsigned Size  = 8;
    localparam int unsigned Chans = 4;
    localparam int unsigned SelW  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [Chans*Size-1:0] in_data;
    logic [Chans-1:0]      in_valid;
    logic [Chans-1:0]      in_ready;
    logic                  mode;
    logic [SelW-1:0]       sel;
    logic [Size-1:0]       out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [SelW-1:0]       out_chan;
`ifdef SCALE_ARB_MUX_PARITY_EN
    logic                  out_par;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic       m_valid;
    logic [7:0] m_data;
    logic [1:0] m_chan;
    int         m_ptr;

    scale_arb_mux #(.Size(Size), .Chans(Chans)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .sel      (sel),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_chan (out_chan)
`ifdef SCALE_ARB_MUX_PARITY_EN
        ,
        .out_par  (out_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        md;
        logic [1:0]  s;
        logic [3:0]  v;
        logic        ordy;
        logic [31:0] d;
        logic [3:0]  e_rdy;
        logic        e_vld;
        logic [7:0]  e_data;
        logic [1:0]  e_chan;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // First channel granted by the rules, -1 for none
    function automatic int ref_grant(input logic md, input logic [1:0] s, input logic [3:0] v, input int ptr);
        if (!md) return v[s] ? int'(s) : -1;
        for (int k = 1; k <= int'(Chans); k++) begin
            int i;
            i = (ptr + k) % int'(Chans);
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive(input logic md, input logic [1:0] s, input logic [3:0] v,
                         input logic ordy, input logic [31:0] d);
        mode      = md;
        sel       = s;
        in_valid  = v;
        out_ready = ordy;
        in_data   = d;
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        drive(1'b0, 2'd0, 4'b0000, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_chan  = 2'd0;
        m_ptr   = int'(Chans) - 1;
    endtask

    // One model-checked cycle with current inputs already driven
    task automatic model_step(input string tag);
        int   g;
        logic le;
        logic [3:0] exp_rdy;
        g  = ref_grant(mode, sel, in_valid, m_ptr);
        le = !m_valid || out_ready;
        exp_rdy = (le && g >= 0) ? 4'(1 << g) : 4'b0000;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (le && g >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*8 +: 8];
            m_chan  = 2'(g);
            if (mode) m_ptr = g;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk({tag, " out_data"}, 32'(out_data), 32'(m_data));
            chk({tag, " out_chan"}, 32'(out_chan), 32'(m_chan));
        end
`ifdef SCALE_ARB_MUX_PARITY_EN
        chk({tag, " out_par"}, 32'(out_par), 32'(^m_data));
`endif
    endtask

    task automatic step_chan(input string tag, input logic [3:0] exp_rdy, input logic [1:0] exp_chan);
        chk({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
        @(posedge clk); #1;
        chk({tag, " out_chan"}, 32'(out_chan), 32'(exp_chan));
    endtask

    localparam logic [31:0] DA = 32'h44A52211;
    localparam logic [31:0] DB = 32'h44332211;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, DA, 4'b0100, 1'b1, 8'hA5, 2'd2};
        tbl[1]  = '{1'b0, 2'd2, 4'b1011, 1'b1, DA, 4'b0000, 1'b0, 8'hA5, 2'd2};
        tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, DB, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, DB, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, DB, 4'b0100, 1'b1, 8'h33, 2'd2};
        tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, DB, 4'b1000, 1'b1, 8'h44, 2'd3};
        tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, DB, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[7]  = '{1'b1, 2'd0, 4'b0101, 1'b1, DB, 4'b0100, 1'b1, 8'h33, 2'd2};
        tbl[8]  = '{1'b1, 2'd0, 4'b0101, 1'b1, DB, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[9]  = '{1'b1, 2'd0, 4'b1000, 1'b1, DB, 4'b1000, 1'b1, 8'h44, 2'd3};
        tbl[10] = '{1'b1, 2'd0, 4'b1111, 1'b0, DB, 4'b0000, 1'b1, 8'h44, 2'd3};
        tbl[11] = '{1'b1, 2'd0, 4'b1111, 1'b0, DB, 4'b0000, 1'b1, 8'h44, 2'd3};
        tbl[12] = '{1'b1, 2'd0, 4'b1111, 1'b0, DB, 4'b0000, 1'b1, 8'h44, 2'd3};
        tbl[13] = '{1'b1, 2'd0, 4'b0000, 1'b1, DB, 4'b0000, 1'b0, 8'h44, 2'd3};
        tbl[14] = '{1'b0, 2'd1, 4'b1111, 1'b0, DB, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[15] = '{1'b1, 2'd0, 4'b1111, 1'b1, DB, 4'b0001, 1'b1, 8'h11, 2'd0};

        // Reset state while rst_n is low
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 4'b1111, 1'b1, DA);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset out_chan", 32'(out_chan), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
`ifdef SCALE_ARB_MUX_PARITY_EN
        chk("reset out_par", 32'(out_par), 32'd0);
`endif
        do_reset();

        // Vector table
        for (int n = 0; n < 16; n++) begin
            drive(tbl[n].md, tbl[n].s, tbl[n].v, tbl[n].ordy, tbl[n].d);
            chk($sformatf("vec%0d in_ready", n), 32'(in_ready), 32'(tbl[n].e_rdy));
            @(posedge clk); #1;
            chk($sformatf("vec%0d out_valid", n), 32'(out_valid), 32'(tbl[n].e_vld));
            chk($sformatf("vec%0d out_data", n), 32'(out_data), 32'(tbl[n].e_data));
            chk($sformatf("vec%0d out_chan", n), 32'(out_chan), 32'(tbl[n].e_chan));
        end

        // Round-robin skip and wrap from a fresh reset
        do_reset();
        drive(1'b1, 2'd0, 4'b0101, 1'b1, DB);
        step_chan("skip g0", 4'b0001, 2'd0);
        step_chan("skip g2", 4'b0100, 2'd2);
        step_chan("skip g0b", 4'b0001, 2'd0);
        step_chan("skip g2b", 4'b0100, 2'd2);
        drive(1'b1, 2'd0, 4'b1000, 1'b1, DB);
        step_chan("wrap g3", 4'b1000, 2'd3);
        drive(1'b1, 2'd0, 4'b1111, 1'b1, DB);
        step_chan("wrap g0", 4'b0001, 2'd0);

        // Asynchronous reset while stalled
        drive(1'b0, 2'd2, 4'b0100, 1'b1, DA);
        @(posedge clk); #1;
        drive(1'b0, 2'd2, 4'b0100, 1'b0, DA);
        @(posedge clk); #1;
        chk("stall out_valid", 32'(out_valid), 32'd1);
        chk("stall out_data", 32'(out_data), 32'hA5);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_data", 32'(out_data), 32'd0);
        chk("midrst out_chan", 32'(out_chan), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd0);
        do_reset();

`ifdef SCALE_ARB_MUX_PARITY_EN
        drive(1'b0, 2'd0, 4'b0001, 1'b1, 32'h00000007);
        @(posedge clk); #1;
        chk("par 07", 32'(out_par), 32'd1);
        drive(1'b0, 2'd0, 4'b0001, 1'b1, 32'h00000003);
        @(posedge clk); #1;
        chk("par 03", 32'(out_par), 32'd0);
        do_reset();
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
                  ($urandom_range(0, 3) != 0), 32'($urandom));
            model_step($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
